user_access_ctrl: RTL
=====================

// Module: user_access_ctrl
// PURPOSE
//  Responder for the game controller's login handshake. Looks up the user ID entered on the switches.
//  Verifies that user's password and returns userIDfoundFlag / accessFlag.
//  Exports whoIsPlaying, the table index used later for high-score storage.
//  After MAX_TRIES wrong passwords it locks out for LOCK_CYCLES clocks.
//  Sits between switch/button debouncers and the game controller FSM.
// PARAMETERS
//  NUM_USERS    4          number of table entries (1..4)
//  ID_TABLE     16'hD730   packed 4-bit IDs: entry0=[3:0]=0, e1=3, e2=7, e3=D
//  PASS_TABLE   16'hF6A5   packed 4-bit passwords: e0=5, e1=A, e2=6, e3=F
//  MAX_TRIES    3          wrong-password attempts allowed before lockout (1..3)
//  LOCK_CYCLES  1000       lockout duration in clk cycles (>=1)
// PORTS
//  clk                  in   1  system clock
//  rst                  in   1  synchronous reset, active-low
//  enableSetUserIDFlag  in   1  from controller: ID entry allowed (level)
//  enableSetPassFlag    in   1  from controller: password entry allowed (level)
//  loadButton_s         in   1  single-cycle load pulse (debounced)
//  logout_s             in   1  single-cycle pulse: end session
//  userIDin             in   4  ID switches
//  passIn               in   4  password switches
//  userIDfoundFlag      out  1  level: valid ID latched
//  accessFlag           out  1  level: password accepted
//  whoIsPlaying         out  4  matched table index (zero-extended)
//  idNotFound_s         out  1  one-cycle pulse: ID scan failed
//  lockedFlag           out  1  level: lockout active
//  attemptsLeft         out  2  remaining password tries
// BEHAVIOUR
//  Reset (rst==0 at posedge, any state):
//   - all flags 0, whoIsPlaying=0, attemptsLeft=MAX_TRIES, state ID_WAIT, scan index 0.
//  States: ID_WAIT, SCAN, PASS_WAIT, GRANTED, LOCKED.
//  ID_WAIT:
//   - loadButton_s && enableSetUserIDFlag at cycle 0: latch userIDin, go SCAN, idx=0.
//   - load pulse with enable low: ignored.
//  SCAN:
//   - one entry per cycle. Cycle 1+k compares entry k with the latched ID.
//   - match at k: whoIsPlaying=k and userIDfoundFlag=1 from cycle 2+k; go PASS_WAIT.
//   - no match by entry NUM_USERS-1: idNotFound_s=1 for one cycle; return to ID_WAIT.
//   - first match (lowest k) wins; duplicate IDs are legal.
//   - loadButton_s and logout_s ignored.
//  PASS_WAIT:
//   - loadButton_s && enableSetPassFlag compares passIn with PASS_TABLE[whoIsPlaying].
//   - match: accessFlag=1 next cycle; go GRANTED; attemptsLeft unchanged.
//   - mismatch, attemptsLeft>1: decrement next cycle; stay.
//   - mismatch, attemptsLeft==1: next cycle attemptsLeft=0, lockedFlag=1,
//     userIDfoundFlag=0, whoIsPlaying=0; go LOCKED.
//   - the same pulse that loaded the ID never counts as a password entry (different state).
//   - logout_s: return to ID_WAIT (see logout).
//  GRANTED:
//   - accessFlag and userIDfoundFlag held high; loadButton_s ignored.
//   - logout_s: return to ID_WAIT (see logout).
//  Logout:
//   - next cycle userIDfoundFlag=0, accessFlag=0, whoIsPlaying=0, attemptsLeft=MAX_TRIES.
//   - logout_s beats loadButton_s in the same cycle.
//  LOCKED:
//   - lockedFlag=1 for exactly LOCK_CYCLES cycles.
//   - then lockedFlag=0, attemptsLeft=MAX_TRIES, state ID_WAIT.
//   - all inputs except rst ignored; counter never wraps.
//  All outputs registered. No combinational path from input to output.
// TESTING
//  1 ID 7 + load -> userIDfoundFlag high 4 cycles after pulse, whoIsPlaying=2;
//    pass 6 + load -> accessFlag high next cycle.
//  2 ID 9 + load -> idNotFound_s single pulse after 4 scan cycles; flags stay 0; back in ID_WAIT.
//  3 ID 0, then passwords 1,2 -> attemptsLeft 2 then 1; then pass 5 -> accessFlag=1, attemptsLeft=1.
//  4 ID 3, three wrong passwords -> lockedFlag=1 for LOCK_CYCLES cycles, userIDfoundFlag=0;
//    loads during lock ignored; then attemptsLeft=3.
//  5 GRANTED, logout_s with loadButton_s in same cycle -> all flags 0, state ID_WAIT, load ignored.
//  6 rst low during SCAN and during LOCKED -> all outputs reset values on next posedge;
//    load with enableSetUserIDFlag=0 -> no action.

Source files
------------

// File: rtl/user_access_ctrl.sv
// Login responder: scans the ID table one entry per cycle, checks the password,
// and enforces a timed lockout after repeated wrong passwords.
module user_access_ctrl #(
    parameter int unsigned NUM_USERS   = 4,
    parameter logic [15:0] ID_TABLE    = 16'hD730,
    parameter logic [15:0] PASS_TABLE  = 16'hF6A5,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enableSetUserIDFlag,
    input  logic       enableSetPassFlag,
    input  logic       loadButton_s,
    input  logic       logout_s,
    input  logic [3:0] userIDin,
    input  logic [3:0] passIn,
    output logic       userIDfoundFlag,
    output logic       accessFlag,
    output logic [3:0] whoIsPlaying,
    output logic       idNotFound_s,
    output logic       lockedFlag,
    output logic [1:0] attemptsLeft
);

    localparam int unsigned CntW     = $clog2(LOCK_CYCLES + 1);
    localparam logic [1:0]  MaxTries = 2'(MAX_TRIES);
    localparam logic [1:0]  LastIdx  = 2'(NUM_USERS - 1);
    localparam logic [CntW-1:0] LockLast = CntW'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {StIdWait, StScan, StPassWait, StGranted, StLocked} state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      id_q, id_d;
    logic            found_q, found_d;
    logic            access_q, access_d;
    logic [1:0]      who_q, who_d;
    logic            nf_q, nf_d;
    logic            locked_q, locked_d;
    logic [1:0]      att_q, att_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [3:0] id_entry;
    logic [3:0] pass_entry;

    assign id_entry   = ID_TABLE[{idx_q, 2'b00} +: 4];
    assign pass_entry = PASS_TABLE[{who_q, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdWait;
            idx_q    <= '0;
            id_q     <= '0;
            found_q  <= 1'b0;
            access_q <= 1'b0;
            who_q    <= '0;
            nf_q     <= 1'b0;
            locked_q <= 1'b0;
            att_q    <= MaxTries;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            id_q     <= id_d;
            found_q  <= found_d;
            access_q <= access_d;
            who_q    <= who_d;
            nf_q     <= nf_d;
            locked_q <= locked_d;
            att_q    <= att_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        id_d     = id_q;
        found_d  = found_q;
        access_d = access_q;
        who_d    = who_q;
        nf_d     = 1'b0;
        locked_d = locked_q;
        att_d    = att_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdWait: begin
                if (loadButton_s && enableSetUserIDFlag) begin
                    id_d    = userIDin;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                // Lowest matching index wins because the scan stops at the first hit.
                if (id_entry == id_q) begin
                    found_d = 1'b1;
                    who_d   = idx_q;
                    state_d = StPassWait;
                end else if (idx_q == LastIdx) begin
                    nf_d    = 1'b1;
                    state_d = StIdWait;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            StPassWait: begin
                if (logout_s) begin
                    found_d  = 1'b0;
                    access_d = 1'b0;
                    who_d    = '0;
                    att_d    = MaxTries;
                    state_d  = StIdWait;
                end else if (loadButton_s && enableSetPassFlag) begin
                    if (passIn == pass_entry) begin
                        access_d = 1'b1;
                        state_d  = StGranted;
                    end else if (att_q > 2'd1) begin
                        att_d = att_q - 2'd1;
                    end else begin
                        att_d    = '0;
                        locked_d = 1'b1;
                        found_d  = 1'b0;
                        who_d    = '0;
                        cnt_d    = '0;
                        state_d  = StLocked;
                    end
                end
            end
            StGranted: begin
                if (logout_s) begin
                    found_d  = 1'b0;
                    access_d = 1'b0;
                    who_d    = '0;
                    att_d    = MaxTries;
                    state_d  = StIdWait;
                end
            end
            StLocked: begin
                if (cnt_q == LockLast) begin
                    locked_d = 1'b0;
                    att_d    = MaxTries;
                    state_d  = StIdWait;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdWait;
        endcase
    end

    assign userIDfoundFlag = found_q;
    assign accessFlag      = access_q;
    assign whoIsPlaying    = {2'b00, who_q};
    assign idNotFound_s    = nf_q;
    assign lockedFlag      = locked_q;
    assign attemptsLeft    = att_q;

endmodule
